// File: rtl/hs_arith_multi_in_minmax_pipe.sv
// Pipelined min/max tree over INPUT_NUM lanes returning value, index and aux payload of the winner.
// Latency S = ceil(clog2(INPUT_NUM)/PIPE_LEVELS) cycles; stalls freeze every full stage, in_ready follows out_ready.
module hs_arith_multi_in_minmax_pipe #(
    parameter int  DATA_WIDTH      = 32,
    parameter int  INPUT_NUM       = 6,
    parameter bit  SELECT_MAX      = 1'b0,
    parameter bit  IS_SIGNED       = 1'b0,
    parameter int  PIPE_LEVELS     = 1,
    parameter bit  ENABLE_AUX_PATH = 1'b1,
    parameter type AUX_DATA_TYPE   = logic,
    localparam int INDEX_WIDTH     = $clog2(INPUT_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [INPUT_NUM-1:0][DATA_WIDTH-1:0] din,
    input  AUX_DATA_TYPE [INPUT_NUM-1:0]         aux_din,
    input  logic [INPUT_NUM-1:0]                 lane_valid,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH-1:0]                out_value,
    output AUX_DATA_TYPE                         out_aux,
    output logic [INDEX_WIDTH-1:0]               out_index,
    output logic                                 out_any_valid
);
    localparam int L  = INDEX_WIDTH;
    localparam int NP = 1 << L;
    localparam int S  = (L + PIPE_LEVELS - 1) / PIPE_LEVELS;

    logic [S-1:0] r_sv;
    logic [S-1:0] w_load;
    logic [S-1:0] w_vin;

    // A stage may load when it or any stage downstream of it has a free slot.
    for (genvar k = 0; k < S; k++) begin : g_ctl
        assign w_load[k] = out_ready | ~(&r_sv[S-1:k]);
        if (k == 0) begin : g_first
            assign w_vin[k] = in_valid;
        end else begin : g_next
            assign w_vin[k] = r_sv[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sv <= '0;
        end else if (flush) begin
            r_sv <= '0;
        end else begin
            r_sv <= (w_load & w_vin) | (~w_load & r_sv);
        end
    end

    assign in_ready = w_load[0] | flush;

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int M = NP >> l;
        logic                   w_v [M];
        logic [DATA_WIDTH-1:0]  w_d [M];
        logic [INDEX_WIDTH-1:0] w_i [M];
        AUX_DATA_TYPE           w_a [M];

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < M; j++) begin : g_lane
                if (j < INPUT_NUM) begin : g_real
                    assign w_v[j] = lane_valid[j];
                    assign w_d[j] = din[j];
                    assign w_i[j] = INDEX_WIDTH'(j);
                    if (ENABLE_AUX_PATH) begin : g_aux
                        assign w_a[j] = aux_din[j];
                    end else begin : g_noaux
                        assign w_a[j] = '0;
                    end
                end else begin : g_pad
                    assign w_v[j] = 1'b0;
                    assign w_d[j] = '0;
                    assign w_i[j] = '0;
                    assign w_a[j] = '0;
                end
            end
        end else begin : g_node
            localparam bit REG = (l % PIPE_LEVELS == 0) || (l == L);
            localparam int K   = (l + PIPE_LEVELS - 1) / PIPE_LEVELS - 1;
            logic                   w_nv [M];
            logic [DATA_WIDTH-1:0]  w_nd [M];
            logic [INDEX_WIDTH-1:0] w_ni [M];
            AUX_DATA_TYPE           w_na [M];

            for (genvar j = 0; j < M; j++) begin : g_sel
                logic                  w_va, w_vb, w_b_gt, w_b_lt, w_pick_b;
                logic [DATA_WIDTH-1:0] w_da, w_db;
                assign w_va = g_lvl[l-1].w_v[2*j];
                assign w_vb = g_lvl[l-1].w_v[2*j+1];
                assign w_da = g_lvl[l-1].w_d[2*j];
                assign w_db = g_lvl[l-1].w_d[2*j+1];
                assign w_b_gt = IS_SIGNED ? ($signed(w_db) > $signed(w_da)) : (w_db > w_da);
                assign w_b_lt = IS_SIGNED ? ($signed(w_db) < $signed(w_da)) : (w_db < w_da);
                // Right (higher-index) side only wins when strictly better, so ties keep the lower index.
                assign w_pick_b = w_vb & (~w_va | (SELECT_MAX ? w_b_gt : w_b_lt));
                assign w_nv[j] = w_va | w_vb;
                assign w_nd[j] = w_pick_b ? w_db : (w_va ? w_da : '0);
                assign w_ni[j] = w_pick_b ? g_lvl[l-1].w_i[2*j+1] : (w_va ? g_lvl[l-1].w_i[2*j] : '0);
                assign w_na[j] = w_pick_b ? g_lvl[l-1].w_a[2*j+1] : (w_va ? g_lvl[l-1].w_a[2*j] : '0);
            end

            if (REG) begin : g_reg
                logic                   r_v [M];
                logic [DATA_WIDTH-1:0]  r_d [M];
                logic [INDEX_WIDTH-1:0] r_i [M];
                AUX_DATA_TYPE           r_a [M];
                always_ff @(posedge clk) begin
                    if (w_load[K]) begin
                        r_v <= w_nv;
                        r_d <= w_nd;
                        r_i <= w_ni;
                        r_a <= w_na;
                    end
                end
                assign w_v = r_v;
                assign w_d = r_d;
                assign w_i = r_i;
                assign w_a = r_a;
            end else begin : g_comb
                assign w_v = w_nv;
                assign w_d = w_nd;
                assign w_i = w_ni;
                assign w_a = w_na;
            end
        end
    end

    assign out_valid     = r_sv[S-1];
    assign out_any_valid = out_valid & g_lvl[L].w_v[0];
    assign out_value     = out_valid ? g_lvl[L].w_d[0] : '0;
    assign out_index     = out_valid ? g_lvl[L].w_i[0] : '0;
    assign out_aux       = out_valid ? g_lvl[L].w_a[0] : '0;
endmodule

// File: tb/tb_hs_arith_multi_in_minmax_pipe.sv
// Directed and streamed checks of the min/max pipeline: 6-lane unsigned min plus 3-lane signed/unsigned max.
module tb_hs_arith_multi_in_minmax_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush;

    logic            m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_any;
    logic [5:0][7:0] m_din, m_aux;
    logic [5:0]      m_lv;
    logic [7:0]      m_value, m_out_aux;
    logic [2:0]      m_index;

    logic            x_in_valid, x_out_ready;
    logic [2:0][7:0] x_din, x_aux;
    logic [2:0]      x_lv;
    logic            s_in_ready, s_out_valid, s_any;
    logic [7:0]      s_value, s_aux;
    logic [1:0]      s_index;
    logic            u_in_ready, u_out_valid, u_any;
    logic [7:0]      u_value, u_aux;
    logic [1:0]      u_index;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       any;
        logic [2:0] idx;
        logic [7:0] val;
        logic [7:0] aux;
    } res_t;

    hs_arith_multi_in_minmax_pipe #(
        .DATA_WIDTH(8), .INPUT_NUM(6), .SELECT_MAX(1'b0), .IS_SIGNED(1'b0),
        .PIPE_LEVELS(1), .ENABLE_AUX_PATH(1'b1), .AUX_DATA_TYPE(logic [7:0])
    ) u_min (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .din(m_din), .aux_din(m_aux), .lane_valid(m_lv), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .out_value(m_value), .out_aux(m_out_aux),
        .out_index(m_index), .out_any_valid(m_any)
    );

    hs_arith_multi_in_minmax_pipe #(
        .DATA_WIDTH(8), .INPUT_NUM(3), .SELECT_MAX(1'b1), .IS_SIGNED(1'b1),
        .PIPE_LEVELS(2), .ENABLE_AUX_PATH(1'b1), .AUX_DATA_TYPE(logic [7:0])
    ) u_smax (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(x_in_valid), .in_ready(s_in_ready),
        .din(x_din), .aux_din(x_aux), .lane_valid(x_lv), .out_valid(s_out_valid),
        .out_ready(x_out_ready), .out_value(s_value), .out_aux(s_aux),
        .out_index(s_index), .out_any_valid(s_any)
    );

    hs_arith_multi_in_minmax_pipe #(
        .DATA_WIDTH(8), .INPUT_NUM(3), .SELECT_MAX(1'b1), .IS_SIGNED(1'b0),
        .PIPE_LEVELS(1), .ENABLE_AUX_PATH(1'b1), .AUX_DATA_TYPE(logic [7:0])
    ) u_umax (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(x_in_valid), .in_ready(u_in_ready),
        .din(x_din), .aux_din(x_aux), .lane_valid(x_lv), .out_valid(u_out_valid),
        .out_ready(x_out_ready), .out_value(u_value), .out_aux(u_aux),
        .out_index(u_index), .out_any_valid(u_any)
    );

    function automatic res_t ref_min(input logic [5:0][7:0] d, input logic [5:0] lv);
        res_t r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (lv[i] && (!r.any || d[i] < r.val)) begin
                r.any = 1'b1;
                r.val = d[i];
                r.idx = 3'(i);
                r.aux = 8'hA0 + 8'(i);
            end
        end
        return r;
    endfunction

    // Drives one vector into the 6-lane unit and returns on the negedge after the accept edge.
    task automatic put_min(input logic [5:0][7:0] d, input logic [5:0] lv);
        @(negedge clk);
        m_din = d; m_lv = lv; m_in_valid = 1'b1;
        @(negedge clk);
        m_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        m_in_valid = 1'b0; m_out_ready = 1'b1; m_din = '0; m_lv = '0;
        x_in_valid = 1'b0; x_out_ready = 1'b1; x_din = '0; x_lv = '0;
        for (int i = 0; i < 6; i++) m_aux[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 3; i++) x_aux[i] = 8'hB0 + 8'(i);
        #22;
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", m_out_valid); end
        checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", m_in_ready); end
        checks++; if ({m_value, m_index, m_out_aux, m_any} !== 20'd0) begin failures++; $display("FAIL rst_outputs got=%h exp=0", {m_value, m_index, m_out_aux, m_any}); end
        checks++; if ({s_out_valid, u_out_valid} !== 2'b00) begin failures++; $display("FAIL rst_max_valid got=%b exp=00", {s_out_valid, u_out_valid}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({m_in_ready, s_in_ready, u_in_ready} !== 3'b111) begin failures++; $display("FAIL rst_release_ready got=%b exp=111", {m_in_ready, s_in_ready, u_in_ready}); end
    endtask

    task automatic test_min_basic();
        logic [5:0][7:0] d;
        d[0] = 8'd9; d[1] = 8'd3; d[2] = 8'd7; d[3] = 8'd3; d[4] = 8'd200; d[5] = 8'd1;
        @(negedge clk);
        m_din = d; m_lv = 6'b101111; m_in_valid = 1'b1;
        #1;
        checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", m_in_ready); end
        @(negedge clk);
        m_in_valid = 1'b0;
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat1 got=%b exp=0", m_out_valid); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat2 got=%b exp=0", m_out_valid); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1) begin failures++; $display("FAIL basic_lat3 got=%b exp=1", m_out_valid); end
        checks++; if (m_value !== 8'd1) begin failures++; $display("FAIL basic_value got=%0d exp=1", m_value); end
        checks++; if (m_index !== 3'd5) begin failures++; $display("FAIL basic_index got=%0d exp=5", m_index); end
        checks++; if ({m_out_aux, m_any} !== {8'hA5, 1'b1}) begin failures++; $display("FAIL basic_aux_any got=%h/%b exp=a5/1", m_out_aux, m_any); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL basic_no_dup got=%b exp=0", m_out_valid); end
    endtask

    task automatic test_tie();
        logic [5:0][7:0] d;
        d[0] = 8'd9; d[1] = 8'd3; d[2] = 8'd7; d[3] = 8'd3; d[4] = 8'd200; d[5] = 8'd1;
        put_min(d, 6'b011111);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({m_out_valid, m_value, m_index, m_out_aux} !== {1'b1, 8'd3, 3'd1, 8'hA1}) begin
            failures++; $display("FAIL tie_lower_index got v=%b val=%0d idx=%0d aux=%h exp v=1 val=3 idx=1 aux=a1", m_out_valid, m_value, m_index, m_out_aux);
        end
        @(negedge clk);
    endtask

    task automatic test_no_lanes();
        logic [5:0][7:0] d;
        d[0] = 8'd9; d[1] = 8'd3; d[2] = 8'd7; d[3] = 8'd3; d[4] = 8'd200; d[5] = 8'd1;
        put_min(d, 6'b000000);
        @(negedge clk);
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1) begin failures++; $display("FAIL none_valid got=%b exp=1", m_out_valid); end
        checks++; if ({m_any, m_value, m_index, m_out_aux} !== 20'd0) begin
            failures++; $display("FAIL none_outputs got any=%b val=%0d idx=%0d aux=%h exp all 0", m_any, m_value, m_index, m_out_aux);
        end
        @(negedge clk);
    endtask

    task automatic test_signed();
        @(negedge clk);
        x_din[0] = 8'h80; x_din[1] = 8'h7F; x_din[2] = 8'hFF; x_lv = 3'b111; x_in_valid = 1'b1;
        @(negedge clk);
        x_in_valid = 1'b0;
        checks++; if ({s_out_valid, s_value, s_index, s_aux} !== {1'b1, 8'h7F, 2'd1, 8'hB1}) begin
            failures++; $display("FAIL smax_value got v=%b val=%h idx=%0d aux=%h exp v=1 val=7f idx=1 aux=b1", s_out_valid, s_value, s_index, s_aux);
        end
        checks++; if (u_out_valid !== 1'b0) begin failures++; $display("FAIL umax_lat1 got=%b exp=0", u_out_valid); end
        @(negedge clk);
        checks++; if ({u_out_valid, u_value, u_index, u_aux} !== {1'b1, 8'hFF, 2'd2, 8'hB2}) begin
            failures++; $display("FAIL umax_value got v=%b val=%h idx=%0d aux=%h exp v=1 val=ff idx=2 aux=b2", u_out_valid, u_value, u_index, u_aux);
        end
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL smax_no_dup got=%b exp=0", s_out_valid); end
        @(negedge clk);
        x_din[0] = 8'h05; x_din[1] = 8'h05; x_din[2] = 8'h01; x_lv = 3'b111; x_in_valid = 1'b1;
        @(negedge clk);
        x_in_valid = 1'b0;
        checks++; if ({s_value, s_index} !== {8'h05, 2'd0}) begin failures++; $display("FAIL smax_tie got val=%h idx=%0d exp val=05 idx=0", s_value, s_index); end
        @(negedge clk);
        checks++; if ({u_value, u_index, u_any} !== {8'h05, 2'd0, 1'b1}) begin failures++; $display("FAIL umax_tie got val=%h idx=%0d any=%b exp val=05 idx=0 any=1", u_value, u_index, u_any); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [5:0][7:0] d [3];
        logic [5:0]      lv [3];
        logic [7:0]      ev [3];
        logic [2:0]      ei [3];
        d[0][0] = 8'd9;  d[0][1] = 8'd3;  d[0][2] = 8'd7;  d[0][3] = 8'd3;  d[0][4] = 8'd200; d[0][5] = 8'd1;
        d[1][0] = 8'd50; d[1][1] = 8'd40; d[1][2] = 8'd30; d[1][3] = 8'd20; d[1][4] = 8'd10;  d[1][5] = 8'd60;
        d[2] = d[1];
        lv[0] = 6'b111111; lv[1] = 6'b111111; lv[2] = 6'b000011;
        ev[0] = 8'd1; ev[1] = 8'd10; ev[2] = 8'd40;
        ei[0] = 3'd5; ei[1] = 3'd4;  ei[2] = 3'd1;
        m_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_din = d[i]; m_lv = lv[i]; m_in_valid = 1'b1;
            #1;
            checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, m_in_ready); end
        end
        @(negedge clk);
        m_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({m_out_valid, m_value, m_index} !== {1'b1, ev[i], ei[i]}) begin
                failures++; $display("FAIL b2b_result[%0d] got v=%b val=%0d idx=%0d exp v=1 val=%0d idx=%0d", i, m_out_valid, m_value, m_index, ev[i], ei[i]);
            end
            @(negedge clk);
        end
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", m_out_valid); end
    endtask

    task automatic test_stream();
        logic [5:0][7:0] vd [20];
        logic [5:0]      vl [20];
        res_t            ex [20];
        res_t            obs, prev;
        logic            prev_stall;
        int sent, got, cyc, unstable;
        sent = 0; got = 0; cyc = 0; unstable = 0; prev_stall = 1'b0; prev = '0;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 6; j++) vd[i][j] = 8'($urandom_range(0, 15));
            vl[i] = 6'($urandom_range(0, 63));
            ex[i] = ref_min(vd[i], vl[i]);
        end
        while (got < 20 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            m_in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
            if (sent < 20) begin m_din = vd[sent]; m_lv = vl[sent]; end
            m_out_ready = 1'($urandom_range(0, 1));
            #1;
            obs.any = m_any; obs.idx = m_index; obs.val = m_value; obs.aux = m_out_aux;
            if (prev_stall && (m_out_valid !== 1'b1 || obs !== prev)) unstable++;
            prev_stall = m_out_valid && !m_out_ready;
            prev = obs;
            if (m_in_valid && m_in_ready) sent++;
            if (m_out_valid && m_out_ready) begin
                checks++; if (obs !== ex[got]) begin
                    failures++; $display("FAIL stream_result[%0d] got any=%b idx=%0d val=%0d aux=%h exp any=%b idx=%0d val=%0d aux=%h",
                        got, obs.any, obs.idx, obs.val, obs.aux, ex[got].any, ex[got].idx, ex[got].val, ex[got].aux);
                end
                got++;
            end
        end
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        checks++; if (got !== 20) begin failures++; $display("FAIL stream_count got=%0d exp=20", got); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL stream_stall_stable got=%0d exp=0", unstable); end
        repeat (4) @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL stream_no_extra got=%b exp=0", m_out_valid); end
    endtask

    task automatic test_flush();
        logic [5:0][7:0] d;
        int stale;
        stale = 0;
        d[0] = 8'd9; d[1] = 8'd3; d[2] = 8'd7; d[3] = 8'd3; d[4] = 8'd200; d[5] = 8'd1;
        m_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_din = d; m_lv = 6'b111111; m_in_valid = 1'b1;
        end
        @(negedge clk);
        #1;
        checks++; if ({m_out_valid, m_in_ready} !== 2'b10) begin failures++; $display("FAIL flush_full got v/rdy=%b exp=10", {m_out_valid, m_in_ready}); end
        flush = 1'b1;
        #1;
        checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", m_in_ready); end
        @(negedge clk);
        flush = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b1;
        checks++; if ({m_out_valid, m_value} !== 9'd0) begin failures++; $display("FAIL flush_cleared got v=%b val=%0d exp v=0 val=0", m_out_valid, m_value); end
        repeat (6) begin
            @(negedge clk);
            if (m_out_valid) stale++;
        end
        checks++; if (stale !== 0) begin failures++; $display("FAIL flush_stale got=%0d exp=0", stale); end
    endtask

    task automatic test_reset_mid();
        logic [5:0][7:0] d;
        d[0] = 8'd50; d[1] = 8'd40; d[2] = 8'd30; d[3] = 8'd20; d[4] = 8'd10; d[5] = 8'd60;
        m_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_din = d; m_lv = 6'b111111; m_in_valid = 1'b1;
        end
        @(negedge clk);
        m_in_valid = 1'b0;
        checks++; if (m_out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=1", m_out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({m_out_valid, m_value, m_index, m_out_aux, m_any} !== 21'd0) begin
            failures++; $display("FAIL rmid_outputs got v=%b val=%0d idx=%0d aux=%h any=%b exp all 0", m_out_valid, m_value, m_index, m_out_aux, m_any);
        end
        checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", m_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        put_min(d, 6'b111110);
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale got=%b exp=0", m_out_valid); end
        @(negedge clk);
        @(negedge clk);
        checks++; if ({m_out_valid, m_value, m_index, m_out_aux} !== {1'b1, 8'd10, 3'd4, 8'hA4}) begin
            failures++; $display("FAIL rmid_result got v=%b val=%0d idx=%0d aux=%h exp v=1 val=10 idx=4 aux=a4", m_out_valid, m_value, m_index, m_out_aux);
        end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_after got=%b exp=0", m_out_valid); end
    endtask

    initial begin
        test_reset();
        test_min_basic();
        test_tie();
        test_no_lanes();
        test_signed();
        test_back_to_back();
        test_stream();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
